router_reg_gen: RTL and testbench

Parametrised next-generation datapath register stage for the 1xN router. It sits between the router FSM and the per-destination FIFOs, and does four things:
- latches the header;
- forwards payload to the FIFO write bus;
- absorbs bytes arriving while the target FIFO is full in a SKID_DEPTH-entry skid buffer (replacing the single full-byte register);
- accumulates running parity and checks it against the trailing parity byte, flagging parity and overflow errors.

---
 rtl/router_pkg.sv | 18 +
 rtl/router_skid_buf.sv | 66 ++++++
 rtl/router_reg_gen.sv | 180 ++++++++++++++++++
 tb/tb_router_reg_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router datapath register stage: default widths,
// header field positions and the skid buffer entry layout.
package router_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    // Header layout: destination in the low bits, expected length above it
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB  = HDR_ADDR_LSB + DEF_ADDR_W;

    // Skid entry: tag bit marks the trailing parity byte
    typedef struct packed {
        logic                  is_par;
        logic [DEF_DATA_W-1:0] data;
    } skid_entry_t;

endpackage

// File: rtl/router_skid_buf.sv
// Small circular FIFO that holds bytes arriving while the destination FIFO is
// full. A pop and a push in the same cycle are allowed, even when full.
module router_skid_buf #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer wrap and occupancy tracking; clr flushes the buffer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/router_reg_gen.sv
// Router datapath register stage: latches the header, forwards payload to the
// FIFO write bus, absorbs bytes during FIFO-full in a skid buffer and checks
// the trailing parity byte.
// Optional build macro ROUTER_LEN_CHECK_EN adds a payload length check driven
// by the upper header bits; without it len_err is tied low.
module router_reg_gen
    import router_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_DEST   = 3,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_W      = $clog2(SKID_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              skid_empty,
    output logic [CNT_W-1:0]  skid_count,
    output logic              low_pkt_valid,
    output logic              parity_done,
    output logic              err,
    output logic              len_err
);

    localparam int              LEN_W      = DATA_W - ADDR_W;
    localparam logic [ADDR_W:0] NUM_DEST_C = (ADDR_W + 1)'(NUM_DEST);

    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] int_par;
    logic [DATA_W-1:0] pkt_par;
    logic              ovf;
    logic              chk_done;
    logic              len_bad;

    logic              hdr_cap;
    logic              dir_wr;
    logic              skid_push;
    logic              skid_pop;
    logic              drop;
    logic              accept;
    logic              wr_is_par;
    logic              skid_full;
    logic [DATA_W:0]   skid_in;
    logic [DATA_W:0]   skid_head;

    // full_state needs no action here: bytes are only taken in ld_state
    logic unused_full_state;
    assign unused_full_state = full_state;

    assign skid_in = {~pkt_valid, data_in};

    router_skid_buf #(
        .WIDTH (DATA_W + 1),
        .DEPTH (SKID_DEPTH),
        .CNT_W (CNT_W)
    ) u_skid (
        .clock  (clock),
        .resetn (resetn),
        .clr    (hdr_cap),
        .push   (skid_push),
        .pop    (skid_pop),
        .wdata  (skid_in),
        .rdata  (skid_head),
        .count  (skid_count),
        .full   (skid_full),
        .empty  (skid_empty)
    );

    // Decode the cycle's action: header capture, direct write, skid push/pop or drop
    always_comb begin
        hdr_cap   = detect_add && pkt_valid &&
                    ({1'b0, data_in[HDR_ADDR_LSB +: ADDR_W]} < NUM_DEST_C);
        dir_wr    = 1'b0;
        skid_push = 1'b0;
        skid_pop  = 1'b0;
        drop      = 1'b0;
        if (ld_state) begin
            if (fifo_full) begin
                if (skid_full) drop = 1'b1;
                else           skid_push = 1'b1;
            end else if (skid_empty) begin
                dir_wr = 1'b1;
            end else begin
                skid_pop  = 1'b1;
                skid_push = 1'b1;
            end
        end else if (laf_state && !fifo_full && !skid_empty) begin
            skid_pop = 1'b1;
        end
        accept    = ld_state && !drop;
        wr_is_par = !lfd_state && ((dir_wr && !pkt_valid) || (skid_pop && skid_head[DATA_W]));
    end

    // FIFO write bus: header, direct payload, or skid head, in that priority
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (lfd_state) begin
            dout       <= hdr;
            dout_valid <= 1'b1;
        end else if (dir_wr) begin
            dout       <= data_in;
            dout_valid <= 1'b1;
        end else if (skid_pop) begin
            dout       <= skid_head[DATA_W-1:0];
            dout_valid <= 1'b1;
        end else begin
            dout_valid <= 1'b0;
        end
    end

`ifdef ROUTER_LEN_CHECK_EN
    logic [LEN_W-1:0] byte_cnt;

    assign len_bad = (byte_cnt != hdr[HDR_ADDR_LSB + ADDR_W +: LEN_W]);

    // Count every payload byte presented in ld_state, dropped ones included
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                     byte_cnt <= '0;
        else if (hdr_cap)                byte_cnt <= '0;
        else if (ld_state && pkt_valid)  byte_cnt <= byte_cnt + 1'b1;
    end
`else
    assign len_bad = 1'b0;
`endif

    // Header, parity accumulation and end-of-packet error evaluation
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hdr         <= '0;
            int_par     <= '0;
            pkt_par     <= '0;
            ovf         <= 1'b0;
            parity_done <= 1'b0;
            err         <= 1'b0;
            len_err     <= 1'b0;
            chk_done    <= 1'b0;
        end else if (hdr_cap) begin
            hdr         <= data_in;
            int_par     <= '0;
            pkt_par     <= '0;
            ovf         <= 1'b0;
            parity_done <= 1'b0;
            err         <= 1'b0;
            len_err     <= 1'b0;
            chk_done    <= 1'b0;
        end else begin
            if (lfd_state)                  int_par <= hdr;
            else if (accept && pkt_valid)   int_par <= int_par ^ data_in;
            if (accept && !pkt_valid)       pkt_par <= data_in;
            if (drop)                       ovf <= 1'b1;
            if (wr_is_par)                  parity_done <= 1'b1;
            if (parity_done && !chk_done) begin
                err      <= (int_par != pkt_par) || ovf || len_bad;
                len_err  <= len_bad;
                chk_done <= 1'b1;
            end
        end
    end

    // Parity-byte-accepted flag; the FSM clear wins over a new set
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                      low_pkt_valid <= 1'b0;
        else if (rst_int_reg)             low_pkt_valid <= 1'b0;
        else if (accept && !pkt_valid)    low_pkt_valid <= 1'b1;
    end

endmodule

// File: tb/tb_router_reg_gen.sv
// Scoreboard bench for router_reg_gen: stimulus pushes expected FIFO bytes and
// end-of-packet status into queues; a negedge monitor pops and compares.
module tb_router_reg_gen;
    import router_pkg::*;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 2;
    localparam int NUM_DEST   = 3;
    localparam int SKID_DEPTH = 2;
    localparam int CNT_W      = 2;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              pkt_valid = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              fifo_full = 1'b0;
    logic              detect_add = 1'b0;
    logic              lfd_state = 1'b0;
    logic              ld_state = 1'b0;
    logic              laf_state = 1'b0;
    logic              full_state = 1'b0;
    logic              rst_int_reg = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              skid_empty;
    logic [CNT_W-1:0]  skid_count;
    logic              low_pkt_valid;
    logic              parity_done;
    logic              err;
    logic              len_err;

    always #5 clock = ~clock;

    router_reg_gen #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_DEST(NUM_DEST),
        .SKID_DEPTH(SKID_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout), .dout_valid(dout_valid),
        .skid_empty(skid_empty), .skid_count(skid_count), .low_pkt_valid(low_pkt_valid),
        .parity_done(parity_done), .err(err), .len_err(len_err)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [1:0] st_q[$];
    logic [7:0] pay[16];
    logic       ffp[16];
    logic       pd_prev = 1'b0;
    logic       chk_pending = 1'b0;
    logic [1:0] st_s;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every written byte and every end-of-packet status is checked here
    always @(negedge clock) begin
        if (!resetn) begin
            pd_prev     = 1'b0;
            chk_pending = 1'b0;
        end else begin
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dout_unexpected actual=%0h required=none", dout);
                end else begin
                    chk("dout", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
            if (chk_pending) begin
                chk_pending = 1'b0;
                if (st_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL status_unexpected actual=%0b required=none", err);
                end else begin
                    st_s = st_q.pop_front();
                    chk("err", 32'(err), 32'(st_s[1]));
                    chk("len_err", 32'(len_err), 32'(st_s[0]));
                end
            end
            if (parity_done && !pd_prev) chk_pending = 1'b1;
            pd_prev = parity_done;
        end
    end

    // Reference model plus driver for one packet: n payload bytes in pay[],
    // per-byte fifo_full in ffp[0..n] (index n is the parity byte)
    task automatic send_pkt(input logic [7:0] h, input int n, input logic [7:0] par);
        logic [7:0] mq[$];
        logic [7:0] x;
        logic [7:0] b;
        logic       dropped;
        logic       any_drop;
        logic       exp_err;
        logic       exp_len;
        int         occ[16];
        int         cnt;
        int         k;
        x = h; any_drop = 1'b0; cnt = 0;
        exp_q.push_back(h);
        for (int i = 0; i <= n; i++) begin
            b = (i < n) ? pay[i] : par;
            dropped = 1'b0;
            if (ffp[i]) begin
                if (mq.size() < SKID_DEPTH) mq.push_back(b);
                else dropped = 1'b1;
            end else if (mq.size() == 0) begin
                exp_q.push_back(b);
            end else begin
                exp_q.push_back(mq.pop_front());
                mq.push_back(b);
            end
            occ[i] = mq.size();
            if (i < n) begin
                cnt++;
                if (!dropped) x = x ^ b;
            end
            any_drop = any_drop | dropped;
        end
        while (mq.size() > 0) exp_q.push_back(mq.pop_front());
`ifdef ROUTER_LEN_CHECK_EN
        exp_len = (cnt != int'(h[7:2]));
`else
        exp_len = 1'b0;
`endif
        exp_err = (x != par) || any_drop || exp_len;
        st_q.push_back({exp_err, exp_len});

        detect_add = 1'b1; pkt_valid = 1'b1; data_in = h;
        cycle();
        detect_add = 1'b0; pkt_valid = 1'b0; lfd_state = 1'b1;
        cycle();
        lfd_state = 1'b0; ld_state = 1'b1;
        for (int i = 0; i <= n; i++) begin
            data_in   = (i < n) ? pay[i] : par;
            pkt_valid = (i < n);
            fifo_full = ffp[i];
            cycle();
            chk("skid_count", 32'(skid_count), 32'(occ[i]));
        end
        ld_state = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
        chk("low_pkt_valid", 32'(low_pkt_valid), 32'd1);
        laf_state = 1'b1; k = 0;
        while (!skid_empty && k < SKID_DEPTH + 2) begin
            cycle();
            k++;
        end
        laf_state = 1'b0;
        chk("skid_drained", 32'(skid_empty), 32'd1);
        rst_int_reg = 1'b1;
        cycle();
        rst_int_reg = 1'b0;
        chk("low_pkt_valid_clr", 32'(low_pkt_valid), 32'd0);
        repeat (3) cycle();
        chk("parity_done", 32'(parity_done), 32'd1);
        chk("err_held", 32'(err), 32'(exp_err));
    endtask

    task automatic set_pay3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        pay[0] = a; pay[1] = b; pay[2] = c;
    endtask

    task automatic set_ff4(input logic f0, input logic f1, input logic f2, input logic f3);
        ffp[0] = f0; ffp[1] = f1; ffp[2] = f2; ffp[3] = f3;
    endtask

    initial begin
        logic [7:0] h;
        logic [7:0] par;
        logic [5:0] lenv;
        logic [1:0] addrv;
        int         n;

        #12;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_skid_empty", 32'(skid_empty), 32'd1);
        chk("rst_skid_count", 32'(skid_count), 32'd0);
        chk("rst_parity_done", 32'(parity_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        cycle();
        resetn = 1'b1;
        cycle();

        // Clean packet, no back-pressure
        set_pay3(8'h11, 8'h22, 8'h33); set_ff4(0, 0, 0, 0);
        send_pkt(8'h0D, 3, 8'h0D);

        // Invalid destination header is ignored; lfd then replays the old header
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h03;
        cycle();
        detect_add = 1'b0; pkt_valid = 1'b0;
        exp_q.push_back(8'h0D);
        lfd_state = 1'b1;
        cycle();
        lfd_state = 1'b0;
        chk("pd_after_bad_hdr", 32'(parity_done), 32'd1);
        cycle();

        // Corrupted parity byte
        set_pay3(8'h11, 8'h22, 8'h33); set_ff4(0, 0, 0, 0);
        send_pkt(8'h0D, 3, 8'hFF);

        // Two bytes absorbed by the skid buffer, then drained in order
        set_pay3(8'h11, 8'h22, 8'h33); set_ff4(1, 1, 0, 0);
        send_pkt(8'h0D, 3, 8'h0D);

        // Third full byte overflows the skid buffer
        set_pay3(8'h11, 8'h22, 8'h33); set_ff4(1, 1, 1, 0);
        send_pkt(8'h0D, 3, 8'h0D);

        // Header announces 4 payload bytes, only 3 sent
        set_pay3(8'h11, 8'h22, 8'h33); set_ff4(0, 0, 0, 0);
        send_pkt(8'h11, 3, 8'h11);

        // Reset in the middle of a payload
        exp_q.push_back(8'h0D); exp_q.push_back(8'hA5);
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D;
        cycle();
        detect_add = 1'b0; lfd_state = 1'b1;
        cycle();
        lfd_state = 1'b0; ld_state = 1'b1; data_in = 8'hA5;
        cycle();
        data_in = 8'h5A; fifo_full = 1'b1;
        cycle();
        @(negedge clock);
        #1;
        resetn = 1'b0;
        #1;
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_dout_valid", 32'(dout_valid), 32'd0);
        chk("midrst_skid_count", 32'(skid_count), 32'd0);
        chk("midrst_skid_empty", 32'(skid_empty), 32'd1);
        chk("midrst_parity_done", 32'(parity_done), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        exp_q.delete();
        st_q.delete();
        ld_state = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
        cycle();
        resetn = 1'b1;
        cycle();

        // Randomised packets: lengths, destinations, back-pressure, bad parity, bad length
        for (int p = 0; p < 40; p++) begin
            n     = $urandom_range(1, 5);
            addrv = 2'($urandom_range(0, NUM_DEST - 1));
            lenv  = ($urandom_range(0, 3) == 0) ? 6'(n + 1) : 6'(n);
            h     = {lenv, addrv};
            par   = h;
            for (int i = 0; i < n; i++) begin
                pay[i] = 8'($urandom);
                par    = par ^ pay[i];
                ffp[i] = ($urandom_range(0, 2) == 0);
            end
            ffp[n] = 1'b0;
            if ($urandom_range(0, 3) == 0) par = par ^ 8'(1 << $urandom_range(0, 7));
            send_pkt(h, n, par);
        end

        repeat (5) cycle();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("st_q_empty", 32'(st_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
